// File: rtl/pll_lock_ctrl.sv
// PLL startup sequencer and lock monitor: releases the feedback divider, then
// compares reference and feedback edge counts over back-to-back windows.
module pll_lock_ctrl #(
  parameter int WIN_CYC     = 1000,
  parameter int TOL         = 1,
  parameter int LOCK_WIN    = 4,
  parameter int UNLOCK_WIN  = 2,
  parameter int DIV_RST_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_out,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             ref_clk,
  input  logic             fb_clk,
  output logic             div_rst_n,
  output logic             locked,
  output logic             lock_lost,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] last_ref_cnt,
  output logic [CNT_W-1:0] last_fb_cnt
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIV_RST = 2'd1;
  localparam logic [1:0] ACQUIRE = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  localparam int HOLD_W = (DIV_RST_CYC > 1) ? $clog2(DIV_RST_CYC) : 1;
  localparam int GOOD_W = $clog2(LOCK_WIN + 1);
  localparam int BAD_W  = $clog2(UNLOCK_WIN + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0]  TOL_C     = CNT_W'(TOL);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DIV_RST_CYC - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WIN - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_WIN - 1);

  logic [1:0]        state_reg, state_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [GOOD_W-1:0] good_reg, good_next;
  logic [BAD_W-1:0]  bad_reg, bad_next;
  logic [CNT_W-1:0]  wcnt_reg, wcnt_next;
  logic              div_rst_n_reg, div_rst_n_next;
  logic              locked_reg, locked_next;
  logic              lost_reg, lost_next;
  logic [CNT_W-1:0]  last_ref_reg, last_ref_next;
  logic [CNT_W-1:0]  last_fb_reg, last_fb_next;

  logic                  running, win_done, win_good;
  logic [1:0]            pin_in, edge_det;
  logic [1:0][CNT_W-1:0] win_total;
  logic [CNT_W-1:0]      cnt_diff;

  assign pin_in   = {fb_clk, ref_clk};
  assign running  = enable && (state_reg == ACQUIRE || state_reg == LOCKED);
  assign win_done = running && (wcnt_reg == WIN_LAST);

  // Channel 0 is the reference, channel 1 the feedback.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [2:0]       sync_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          sync_reg <= {sync_reg[1:0], pin_in[gi]};
          cnt_reg  <= (running && !win_done) ? win_total[gi] : '0;
        end
      end

      assign edge_det[gi]  = sync_reg[1] & ~sync_reg[2];
      // Includes the edge seen in the current cycle so the window's last cycle counts.
      assign win_total[gi] = (cnt_reg == CNT_MAX) ? CNT_MAX
                                                  : cnt_reg + CNT_W'(edge_det[gi]);
    end
  endgenerate

  assign cnt_diff = (win_total[0] >= win_total[1]) ? (win_total[0] - win_total[1])
                                                   : (win_total[1] - win_total[0]);
  assign win_good = (cnt_diff <= TOL_C);

  assign wcnt_next = (running && !win_done) ? (wcnt_reg + CNT_W'(1)) : '0;

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    good_next      = good_reg;
    bad_next       = bad_reg;
    div_rst_n_next = div_rst_n_reg;
    locked_next    = locked_reg;
    lost_next      = 1'b0;
    last_ref_next  = last_ref_reg;
    last_fb_next   = last_fb_reg;

    if (!enable) begin
      state_next     = IDLE;
      hold_next      = '0;
      good_next      = '0;
      bad_next       = '0;
      div_rst_n_next = 1'b0;
      locked_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next     = DIV_RST;
          hold_next      = '0;
          good_next      = '0;
          bad_next       = '0;
          div_rst_n_next = 1'b0;
          locked_next    = 1'b0;
        end
        DIV_RST: begin
          div_rst_n_next = 1'b0;
          if (hold_reg == HOLD_LAST) begin
            state_next     = ACQUIRE;
            hold_next      = '0;
            div_rst_n_next = 1'b1;
          end else begin
            hold_next = hold_reg + HOLD_W'(1);
          end
        end
        ACQUIRE: begin
          if (win_done) begin
            last_ref_next = win_total[0];
            last_fb_next  = win_total[1];
            if (!win_good) begin
              good_next = '0;
            end else if (good_reg == GOOD_LAST) begin
              state_next  = LOCKED;
              locked_next = 1'b1;
              good_next   = '0;
              bad_next    = '0;
            end else begin
              good_next = good_reg + GOOD_W'(1);
            end
          end
        end
        default: begin
          if (win_done) begin
            last_ref_next = win_total[0];
            last_fb_next  = win_total[1];
            if (win_good) begin
              bad_next = '0;
            end else if (bad_reg == BAD_LAST) begin
              // Divider keeps running; only the lock search restarts.
              state_next  = ACQUIRE;
              locked_next = 1'b0;
              lost_next   = 1'b1;
              good_next   = '0;
              bad_next    = '0;
            end else begin
              bad_next = bad_reg + BAD_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      good_reg      <= '0;
      bad_reg       <= '0;
      wcnt_reg      <= '0;
      div_rst_n_reg <= 1'b0;
      locked_reg    <= 1'b0;
      lost_reg      <= 1'b0;
      last_ref_reg  <= '0;
      last_fb_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      good_reg      <= good_next;
      bad_reg       <= bad_next;
      wcnt_reg      <= wcnt_next;
      div_rst_n_reg <= div_rst_n_next;
      locked_reg    <= locked_next;
      lost_reg      <= lost_next;
      last_ref_reg  <= last_ref_next;
      last_fb_reg   <= last_fb_next;
    end
  end

  assign state        = state_reg;
  assign div_rst_n    = div_rst_n_reg;
  assign locked       = locked_reg;
  assign lock_lost    = lost_reg;
  assign last_ref_cnt = last_ref_reg;
  assign last_fb_cnt  = last_fb_reg;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed scenarios plus a randomized soak, all checked
// every cycle against a window-level reference model of the lock procedure.
module tb_pll_lock_ctrl;
  localparam int WIN_CYC     = 200;
  localparam int TOL         = 1;
  localparam int LOCK_WIN    = 4;
  localparam int UNLOCK_WIN  = 2;
  localparam int DIV_RST_CYC = 16;
  localparam int CNT_W       = 16;
  localparam int MAXC        = (1 << CNT_W) - 1;

  logic             clk_out = 1'b0;
  logic             rst_n   = 1'b0;
  logic             enable  = 1'b0;
  logic             ref_clk = 1'b0;
  logic             fb_clk  = 1'b0;
  logic             div_rst_n, locked, lock_lost;
  logic [1:0]       state;
  logic [CNT_W-1:0] last_ref_cnt, last_fb_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pll_lock_ctrl #(
    .WIN_CYC(WIN_CYC), .TOL(TOL), .LOCK_WIN(LOCK_WIN), .UNLOCK_WIN(UNLOCK_WIN),
    .DIV_RST_CYC(DIV_RST_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk_out(clk_out), .rst_n(rst_n), .enable(enable), .ref_clk(ref_clk),
    .fb_clk(fb_clk), .div_rst_n(div_rst_n), .locked(locked), .lock_lost(lock_lost),
    .state(state), .last_ref_cnt(last_ref_cnt), .last_fb_cnt(last_fb_cnt)
  );

  always #5 clk_out = ~clk_out;

  // Reference model: phase, elapsed time in phase, window totals, run lengths.
  int m_st, m_hold, m_wt, m_r, m_f, m_good, m_bad;
  int m_div, m_lk, m_lost, m_lr, m_lf;
  bit m_wdone;
  bit rq[$];
  bit fq[$];

  // Pin generators.
  int ref_ph, ref_half, ref_gate_left, fbc, n_rp, n_fp;
  bit ref_stop, fb_hold0, pmode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_hold = 0; m_wt = 0; m_r = 0; m_f = 0; m_good = 0; m_bad = 0;
    m_div = 0; m_lk = 0; m_lost = 0; m_lr = 0; m_lf = 0; m_wdone = 0;
    rq.delete(); fq.delete();
    for (int i = 0; i < 3; i++) begin
      rq.push_back(1'b0);
      fq.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    int er, ef, tr, tf, d;
    bit good;
    // Pin samples three edges back and two edges back form the edge seen now.
    er = (rq[1] && !rq[0]) ? 1 : 0;
    ef = (fq[1] && !fq[0]) ? 1 : 0;
    rq.push_back(ref_clk); void'(rq.pop_front());
    fq.push_back(fb_clk);  void'(fq.pop_front());
    m_lost = 0;
    m_wdone = 0;
    if (!enable) begin
      m_st = 0; m_div = 0; m_lk = 0; m_hold = 0; m_good = 0; m_bad = 0;
      m_wt = 0; m_r = 0; m_f = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_hold = DIV_RST_CYC;
    end else if (m_st == 1) begin
      m_hold--;
      if (m_hold == 0) begin
        m_st = 2; m_div = 1; m_wt = 0; m_r = 0; m_f = 0; m_good = 0;
      end
    end else begin
      tr = (m_r + er > MAXC) ? MAXC : m_r + er;
      tf = (m_f + ef > MAXC) ? MAXC : m_f + ef;
      if (m_wt == WIN_CYC - 1) begin
        m_wdone = 1;
        m_lr = tr; m_lf = tf;
        d = (tr > tf) ? tr - tf : tf - tr;
        good = (d <= TOL);
        m_wt = 0; m_r = 0; m_f = 0;
        if (m_st == 2) begin
          if (!good) m_good = 0;
          else begin
            m_good++;
            if (m_good >= LOCK_WIN) begin m_st = 3; m_lk = 1; m_bad = 0; end
          end
        end else begin
          if (good) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad >= UNLOCK_WIN) begin
              m_st = 2; m_lk = 0; m_lost = 1; m_good = 0;
            end
          end
        end
      end else begin
        m_wt++; m_r = tr; m_f = tf;
      end
    end
  endtask

  function automatic logic pulse_at(input int pos, input int n);
    return (pos >= 10) && (((pos - 10) % 8) < 4) && (((pos - 10) / 8) < n);
  endfunction

  task automatic drive_pins();
    if (pmode) begin
      ref_clk = pulse_at(m_wt, n_rp);
      fb_clk  = pulse_at(m_wt, n_fp);
    end else begin
      ref_ph++;
      if (ref_ph >= 2 * ref_half) ref_ph = 0;
      ref_clk = (ref_ph < ref_half) && !ref_stop && (ref_gate_left == 0);
      if (ref_gate_left > 0) ref_gate_left--;
      // Behaves like a /10 divider held in reset by div_rst_n.
      if (div_rst_n !== 1'b1) begin
        fbc = 0; fb_clk = 1'b0;
      end else begin
        fbc = (fbc + 1) % 10;
        fb_clk = (fbc >= 5) && !fb_hold0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_out);
    if (rst_n) model_step();
    #1;
    chk("state", state, m_st);
    chk("div_rst_n", div_rst_n, m_div);
    chk("locked", locked, m_lk);
    chk("lock_lost", lock_lost, m_lost);
    chk("last_ref_cnt", last_ref_cnt, m_lr);
    chk("last_fb_cnt", last_fb_cnt, m_lf);
    if (m_wdone)
      $display("window: state=%0d R=%0d F=%0d locked=%0d lost=%0d",
               state, last_ref_cnt, last_fb_cnt, locked, lock_lost);
    drive_pins();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance to the first cycle of a window (a window has just completed).
  task automatic align();
    int k;
    k = 0;
    do begin tick(); k++; end
    while (!(m_wt == 0 && m_st >= 2) && k <= WIN_CYC + DIV_RST_CYC + 2);
    chk("align_running", (state >= 2'd2) ? 1 : 0, 1);
  endtask

  task automatic wait_lock(input string tag, input int bound);
    int k;
    k = 0;
    while (locked !== 1'b1 && k < bound) begin tick(); k++; end
    chk(tag, locked, 1);
  endtask

  initial begin
    int t;
    bit seen;

    model_reset();
    ref_ph = $urandom_range(0, 9); ref_half = 5; ref_gate_left = 0; fbc = 0;
    ref_stop = 0; fb_hold0 = 0; pmode = 0; n_rp = 0; n_fp = 0;

    // Reset held with ref toggling, then idle with enable low.
    run(20);
    chk("rst_state", state, 0);
    chk("rst_lost", lock_lost, 0);
    rst_n = 1'b1;
    run(100);
    chk("idle_state", state, 0);
    chk("idle_div", div_rst_n, 0);

    // Nominal acquisition: divider release and lock timing.
    enable = 1'b1;
    t = 0;
    do begin tick(); t++; end while (div_rst_n !== 1'b1 && t < 100);
    chk("div_release_cycle", t, DIV_RST_CYC + 1);
    do begin tick(); t++; end while (locked !== 1'b1 && t < 5000);
    chk("lock_cycle", t, DIV_RST_CYC + 1 + LOCK_WIN * WIN_CYC);
    chk("lock_state", state, 3);
    chk("lock_ref_cnt", last_ref_cnt, 20);

    // Reference lost for two full windows.
    align();
    ref_stop = 1;
    t = 0; seen = 0;
    while (!seen && t < 3 * WIN_CYC) begin tick(); t++; if (lock_lost === 1'b1) seen = 1; end
    chk("unlock_cycle", t, 2 * WIN_CYC);
    chk("unlock_state", state, 2);
    chk("unlock_locked", locked, 0);
    chk("unlock_ref_cnt", last_ref_cnt, 0);
    chk("unlock_fb_cnt", last_fb_cnt, 20);
    tick();
    chk("lost_one_cycle", lock_lost, 0);
    ref_stop = 0;
    wait_lock("relock", (LOCK_WIN + 2) * WIN_CYC);

    // One short-gated window does not drop lock.
    align();
    ref_gate_left = 80;
    run(WIN_CYC);
    chk("gated_window_bad", (last_ref_cnt <= 13) ? 1 : 0, 1);
    chk("gated_still_locked", locked, 1);
    seen = 0;
    for (int i = 0; i < 3 * WIN_CYC; i++) begin tick(); if (lock_lost === 1'b1) seen = 1; end
    chk("gated_no_lost", seen, 0);
    chk("gated_locked", locked, 1);

    // Tolerance boundary with exact pulse counts: diff 1 good, diff 2 bad.
    align();
    pmode = 1; n_rp = 21; n_fp = 20;
    run(WIN_CYC);
    run(WIN_CYC);
    chk("tol1_ref", last_ref_cnt, 21);
    chk("tol1_fb", last_fb_cnt, 20);
    run(WIN_CYC);
    chk("tol1_locked", locked, 1);
    n_rp = 22;
    run(WIN_CYC);
    chk("tol2_ref", last_ref_cnt, 22);
    chk("tol2_first_locked", locked, 1);
    run(WIN_CYC);
    chk("tol2_fb", last_fb_cnt, 20);
    chk("tol2_lost", lock_lost, 1);
    chk("tol2_state", state, 2);

    // Enable dropped mid-acquire.
    pmode = 0;
    run(50);
    enable = 1'b0;
    tick();
    chk("disable_state", state, 0);
    chk("disable_div", div_rst_n, 0);
    chk("disable_no_lost", lock_lost, 0);
    run(20);

    // Async reset while locked, mid-window.
    enable = 1'b1;
    wait_lock("lock_before_reset", DIV_RST_CYC + (LOCK_WIN + 2) * WIN_CYC);
    run(37);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_div", div_rst_n, 0);
    chk("arst_locked", locked, 0);
    chk("arst_lost", lock_lost, 0);
    chk("arst_ref", last_ref_cnt, 0);
    chk("arst_fb", last_fb_cnt, 0);
    model_reset();
    #1 rst_n = 1'b1;

    // Feedback dead: never locks.
    fb_hold0 = 1;
    seen = 0;
    for (int i = 0; i < DIV_RST_CYC + 1 + LOCK_WIN * WIN_CYC; i++) begin
      tick();
      if (locked === 1'b1) seen = 1;
    end
    chk("nofb_never_locked", seen, 0);
    chk("nofb_state", state, 2);
    chk("nofb_fb_cnt", last_fb_cnt, 0);
    chk("nofb_ref_cnt", last_ref_cnt, 20);
    fb_hold0 = 0;

    // Randomized soak, checked cycle by cycle against the model.
    for (int s = 0; s < 80; s++) begin
      ref_half = $urandom_range(4, 6);
      ref_stop = ($urandom_range(0, 5) == 0);
      fb_hold0 = ($urandom_range(0, 7) == 0);
      enable   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 9) == 0) ref_gate_left = $urandom_range(10, 90);
      run(WIN_CYC / 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
